// File: rtl/rtc_bus_responder.sv
// Responder end of the multiplexed 8-bit RTC bus: BCD clock, BCD countdown timer and control/status.
// Define RESP_SYNC_EN to put a 2-flop synchronizer ahead of the strobe sampling register.
module rtc_bus_responder #(
    parameter logic [7:0] UNMAPPED_VAL = 8'hFF,
    parameter logic [7:0] HOUR_MAX     = 8'h23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ad,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] data_in,
    input  logic       tick,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       irq
);
    localparam int NS = 4;  // strobe vector order {ad, cs, wr, rd}

    logic [NS-1:0] pins;
    logic [NS-1:0] samp_src;
    logic [NS-1:0] samp_reg;
    logic          wr_prev_reg, rd_prev_reg;

    assign pins = {ad, cs, wr, rd};

`ifdef RESP_SYNC_EN
    for (genvar gi = 0; gi < NS; gi++) begin : g_sync
        logic s1_reg, s2_reg;
        always_ff @(posedge clock) begin
            if (!reset) begin
                s1_reg <= 1'b1;
                s2_reg <= 1'b1;
            end else begin
                s1_reg <= pins[gi];
                s2_reg <= s1_reg;
            end
        end
        assign samp_src[gi] = s2_reg;
    end
`else
    assign samp_src = pins;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            samp_reg    <= '1;
            wr_prev_reg <= 1'b1;
            rd_prev_reg <= 1'b1;
        end else begin
            samp_reg    <= samp_src;
            wr_prev_reg <= samp_reg[1];
            rd_prev_reg <= samp_reg[0];
        end
    end

    logic ad_s, cs_s, wr_s, rd_s;
    logic wr_rise, addr_we, data_we, read_act;

    assign ad_s = samp_reg[3];
    assign cs_s = samp_reg[2];
    assign wr_s = samp_reg[1];
    assign rd_s = samp_reg[0];

    // A write strobe overlapping a read strobe is discarded so the read proceeds cleanly.
    assign wr_rise  = wr_s && !wr_prev_reg && !cs_s && rd_s && rd_prev_reg;
    assign addr_we  = wr_rise && !ad_s;
    assign data_we  = wr_rise && ad_s;
    assign read_act = !rd_s && !cs_s;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v >= maxv)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h59;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return v - 8'd1;
    endfunction

    logic [7:0] sec_reg, min_reg, hour_reg, day_reg, month_reg, year_reg;
    logic [7:0] tsec_reg, tmin_reg, thour_reg, addr_reg;
    logic       hold_reg, run_reg, done_reg;
    logic [7:0] data_out_reg;
    logic       data_oe_reg;

    logic [7:0] sec_next, min_next, hour_next, day_next, month_next, year_next;
    logic [7:0] tsec_next, tmin_next, thour_next, addr_next;
    logic       hold_next, run_next, done_next;
    logic [7:0] data_out_next;
    logic       data_oe_next;
    logic [7:0] rdata;

    always_comb begin
        rdata = UNMAPPED_VAL;
        case (addr_reg)
            8'h21:   rdata = sec_reg;
            8'h22:   rdata = min_reg;
            8'h23:   rdata = hour_reg;
            8'h24:   rdata = day_reg;
            8'h25:   rdata = month_reg;
            8'h26:   rdata = year_reg;
            8'h41:   rdata = tsec_reg;
            8'h42:   rdata = tmin_reg;
            8'h43:   rdata = thour_reg;
            8'hF0:   rdata = {done_reg, 5'b0, hold_reg, run_reg};
            default: rdata = UNMAPPED_VAL;
        endcase
    end

    always_comb begin
        sec_next      = sec_reg;
        min_next      = min_reg;
        hour_next     = hour_reg;
        day_next      = day_reg;
        month_next    = month_reg;
        year_next     = year_reg;
        tsec_next     = tsec_reg;
        tmin_next     = tmin_reg;
        thour_next    = thour_reg;
        hold_next     = hold_reg;
        run_next      = run_reg;
        done_next     = done_reg;
        addr_next     = addr_reg;
        data_out_next = UNMAPPED_VAL;
        data_oe_next  = 1'b0;

        if (tick && !hold_reg) begin
            sec_next = bcd_inc(sec_reg, 8'h59);
            if (sec_reg >= 8'h59) begin
                min_next = bcd_inc(min_reg, 8'h59);
                if (min_reg >= 8'h59)
                    hour_next = bcd_inc(hour_reg, HOUR_MAX) & 8'h7F;
            end
        end

        if (tick && run_reg) begin
            if ({thour_reg, tmin_reg, tsec_reg} == 24'h0) begin
                run_next  = 1'b0;
                done_next = 1'b1;
            end else begin
                tsec_next = bcd_dec(tsec_reg);
                if (tsec_reg == 8'h00) begin
                    tmin_next = bcd_dec(tmin_reg);
                    if (tmin_reg == 8'h00)
                        thour_next = bcd_dec(thour_reg);
                end
                if ({thour_next, tmin_next, tsec_next} == 24'h0) begin
                    run_next  = 1'b0;
                    done_next = 1'b1;
                end
            end
        end

        // Bus writes are applied last so they override a same-cycle tick update.
        if (addr_we)
            addr_next = data_in;
        if (data_we) begin
            case (addr_reg)
                8'h21: sec_next   = data_in;
                8'h22: min_next   = data_in;
                8'h23: hour_next  = data_in;
                8'h24: day_next   = data_in;
                8'h25: month_next = data_in;
                8'h26: year_next  = data_in;
                8'h41: tsec_next  = data_in;
                8'h42: tmin_next  = data_in;
                8'h43: thour_next = data_in;
                8'hF0: begin
                    hold_next = data_in[1];
                    run_next  = data_in[0];
                    if (data_in[7])
                        done_next = 1'b0;
                end
                default: ;
            endcase
        end

        if (read_act) begin
            data_oe_next  = 1'b1;
            data_out_next = data_oe_reg ? data_out_reg : rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sec_reg      <= 8'h00;
            min_reg      <= 8'h00;
            hour_reg     <= 8'h00;
            day_reg      <= 8'h00;
            month_reg    <= 8'h00;
            year_reg     <= 8'h00;
            tsec_reg     <= 8'h00;
            tmin_reg     <= 8'h00;
            thour_reg    <= 8'h00;
            hold_reg     <= 1'b0;
            run_reg      <= 1'b0;
            done_reg     <= 1'b0;
            addr_reg     <= 8'hFF;
            data_out_reg <= UNMAPPED_VAL;
            data_oe_reg  <= 1'b0;
        end else begin
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            day_reg      <= day_next;
            month_reg    <= month_next;
            year_reg     <= year_next;
            tsec_reg     <= tsec_next;
            tmin_reg     <= tmin_next;
            thour_reg    <= thour_next;
            hold_reg     <= hold_next;
            run_reg      <= run_next;
            done_reg     <= done_next;
            addr_reg     <= addr_next;
            data_out_reg <= data_out_next;
            data_oe_reg  <= data_oe_next;
        end
    end

    assign data_out = data_out_reg;
    assign data_oe  = data_oe_reg;
    assign irq      = done_reg;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: vector table, directed corner sequences and a randomized run
// against a seconds-counting reference model.
module tb_rtc_bus_responder;
`ifdef RESP_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT  = 2 + SD;
    localparam int HOLD = LAT + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ad = 1'b1, cs = 1'b1, wr = 1'b1, rd = 1'b1, tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe, irq;

    int tests = 0;
    int fails = 0;

    // reference model state: clock/timer fields held as decimal numbers
    int         ms = 0, mm = 0, mh = 0, ts = 0, tm = 0, th = 0;
    logic [7:0] mday = 8'h00, mmon = 8'h00, myear = 8'h00;
    logic       mhold = 1'b0, mrun = 1'b0, mdone = 1'b0;

    rtc_bus_responder dut (
        .clock(clock), .reset(reset), .ad(ad), .cs(cs), .wr(wr), .rd(rd),
        .data_in(data_in), .tick(tick), .data_out(data_out), .data_oe(data_oe), .irq(irq)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
        end else begin
            $display("[TB] %s: 0x%02h ok", name, act);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic addr_phase(input logic [7:0] a);
        cs = 1'b0; ad = 1'b0; data_in = a; wr = 1'b0;
        cyc(2);
        wr = 1'b1;
        cyc(HOLD);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr_phase(a);
        ad = 1'b1; data_in = d; wr = 1'b0;
        cyc(2);
        wr = 1'b1;
        cyc(HOLD);
        cs = 1'b1;
        cyc(HOLD);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        addr_phase(a);
        ad = 1'b1; rd = 1'b0;
        cyc(LAT);
        oe = data_oe; d = data_out;
        rd = 1'b1; cs = 1'b1;
        cyc(HOLD);
    endtask

    task automatic chk_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        bus_read(a, d, oe);
        chk({name, " oe"}, {7'd0, oe}, 8'h01);
        chk(name, d, exp);
    endtask

    task automatic do_tick;
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h21:   return bcd(ms);
            8'h22:   return bcd(mm);
            8'h23:   return bcd(mh);
            8'h24:   return mday;
            8'h25:   return mmon;
            8'h26:   return myear;
            8'h41:   return bcd(ts);
            8'h42:   return bcd(tm);
            8'h43:   return bcd(th);
            8'hF0:   return {mdone, 5'b0, mhold, mrun};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_tick;
        int t;
        if (!mhold) begin
            t  = (ms + 60 * mm + 3600 * mh + 1) % 86400;
            mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
        end
        if (mrun) begin
            t = th * 3600 + tm * 60 + ts;
            if (t > 0) begin
                t--;
                th = t / 3600; tm = (t / 60) % 60; ts = t % 60;
            end
            if (t == 0) begin
                mdone = 1'b1; mrun = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rexp;
    } vec_t;

    localparam logic [7:0] ADDRS [12] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                           8'h41, 8'h42, 8'h43, 8'hF0, 8'h30, 8'h7F};

    initial begin
        vec_t       vt [8];
        logic [7:0] a, d, rdv;
        logic       oe;
        int         op, k, v;

        vt[0] = '{8'h23, 8'h11, 8'h11};
        vt[1] = '{8'h30, 8'h55, 8'hFF};
        vt[2] = '{8'h26, 8'h99, 8'h99};
        vt[3] = '{8'h24, 8'h31, 8'h31};
        vt[4] = '{8'h41, 8'h07, 8'h07};
        vt[5] = '{8'hF0, 8'h03, 8'h03};
        vt[6] = '{8'hF0, 8'h7E, 8'h02};
        vt[7] = '{8'hF0, 8'h80, 8'h00};

        // reset state
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk("reset data_out", data_out, 8'hFF);
        chk("reset data_oe", {7'd0, data_oe}, 8'h00);
        chk("reset irq", {7'd0, irq}, 8'h00);
        chk_read("reset sec", 8'h21, 8'h00);
        chk_read("reset thour", 8'h43, 8'h00);
        chk_read("reset status", 8'hF0, 8'h00);

        // table: write then read back
        for (int i = 0; i < 8; i++) begin
            bus_write(vt[i].addr, vt[i].wdata);
            chk_read($sformatf("vec%0d addr %02h", i, vt[i].addr), vt[i].addr, vt[i].rexp);
        end
        chk_read("after unmapped write hour", 8'h23, 8'h11);

        // read latency, hold while strobed, release
        addr_phase(8'h23);
        ad = 1'b1; rd = 1'b0;
        cyc(LAT - 1);
        chk("lat early oe", {7'd0, data_oe}, 8'h00);
        cyc(1);
        chk("lat oe", {7'd0, data_oe}, 8'h01);
        chk("lat data", data_out, 8'h11);
        cyc(3);
        chk("lat hold data", data_out, 8'h11);
        rd = 1'b1;
        cyc(LAT);
        chk("release oe", {7'd0, data_oe}, 8'h00);
        chk("release data", data_out, 8'hFF);
        cs = 1'b1;
        cyc(HOLD);

        // full rollover
        bus_write(8'h21, 8'h59);
        bus_write(8'h22, 8'h59);
        bus_write(8'h23, 8'h23);
        bus_write(8'h24, 8'h15);
        bus_write(8'hF0, 8'h00);
        do_tick;
        chk_read("roll sec", 8'h21, 8'h00);
        chk_read("roll min", 8'h22, 8'h00);
        chk_read("roll hour", 8'h23, 8'h00);
        chk_read("roll day", 8'h24, 8'h15);

        // countdown to done
        bus_write(8'h43, 8'h00);
        bus_write(8'h42, 8'h00);
        bus_write(8'h41, 8'h02);
        bus_write(8'hF0, 8'h01);
        do_tick;
        do_tick;
        chk_read("timer sec", 8'h41, 8'h00);
        chk_read("timer status", 8'hF0, 8'h80);
        chk("timer irq", {7'd0, irq}, 8'h01);
        bus_write(8'hF0, 8'h80);
        chk("irq cleared", {7'd0, irq}, 8'h00);

        // bus write colliding with a tick on sec
        bus_write(8'h21, 8'h58);
        addr_phase(8'h21);
        ad = 1'b1; data_in = 8'h05; wr = 1'b0;
        cyc(2);
        wr = 1'b1;
        cyc(1 + SD);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(HOLD);
        cs = 1'b1;
        cyc(HOLD);
        chk_read("collide sec", 8'h21, 8'h05);
        chk_read("collide min", 8'h22, 8'h00);
        bus_write(8'hF0, 8'h02);
        do_tick; do_tick; do_tick;
        chk_read("hold sec", 8'h21, 8'h05);

        // reset in the middle of a read
        addr_phase(8'h21);
        ad = 1'b1; rd = 1'b0;
        cyc(LAT);
        chk("pre-reset oe", {7'd0, data_oe}, 8'h01);
        reset = 1'b0;
        cyc(1);
        chk("mid-reset oe", {7'd0, data_oe}, 8'h00);
        chk("mid-reset data", data_out, 8'hFF);
        reset = 1'b1; rd = 1'b1; cs = 1'b1; ad = 1'b1;
        cyc(HOLD);
        chk_read("post-reset sec", 8'h21, 8'h00);
        chk_read("post-reset status", 8'hF0, 8'h00);

        // randomized run against the model
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            k  = $urandom_range(0, 11);
            a  = ADDRS[k];
            if (op < 4) begin
                d = 8'($urandom);
                case (k)
                    0: begin v = $urandom_range(0, 59); ms = v; d = bcd(v); end
                    1: begin v = $urandom_range(0, 59); mm = v; d = bcd(v); end
                    2: begin v = $urandom_range(0, 23); mh = v; d = bcd(v); end
                    3: mday = d;
                    4: mmon = d;
                    5: myear = d;
                    6: begin v = $urandom_range(0, 12); ts = v; d = bcd(v); end
                    7: begin v = $urandom_range(0, 1); tm = v; d = bcd(v); end
                    8: begin v = $urandom_range(0, 1); th = v; d = bcd(v); end
                    9: begin
                        d[1] = ($urandom_range(0, 3) == 0);
                        mhold = d[1];
                        mrun  = d[0];
                        if (d[7]) mdone = 1'b0;
                    end
                    default: ;
                endcase
                bus_write(a, d);
            end else if (op < 7) begin
                do_tick;
                model_tick();
            end else begin
                bus_read(a, rdv, oe);
                chk("rand rd oe", {7'd0, oe}, 8'h01);
                chk($sformatf("rand rd %02h", a), rdv, model_read(a));
            end
            chk($sformatf("rand irq %0d", it), {7'd0, irq}, {7'd0, mdone});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
